// File: rtl/vector_lane_sequencer.sv
// Vector lane sequencer: reads two source vectors in one cycle, streams
// lanes through a shared scalar ALU, then writes the result vector back.
// Ports: clk/reset_n; req_* issue handshake; abort cancel; regfile
// read (vector_op, vector_size, ra1, ra2, rs1_lanes, rs2_lanes) and write
// (we3, wa3, wd_lanes); shared ALU (alu_a, alu_b, alu_ctrl, alu_result);
// status busy, done, err.
module vector_lane_sequencer #(
  parameter int NUM_LANES = 5,
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_op,
  input  logic [2:0]                  req_size,
  input  logic [REG_AW-1:0]           req_ra1,
  input  logic [REG_AW-1:0]           req_ra2,
  input  logic [REG_AW-1:0]           req_wa3,
  input  logic                        abort,
  output logic                        vector_op,
  output logic [2:0]                  vector_size,
  output logic [REG_AW-1:0]           ra1,
  output logic [REG_AW-1:0]           ra2,
  input  logic [NUM_LANES*DATA_W-1:0] rs1_lanes,
  input  logic [NUM_LANES*DATA_W-1:0] rs2_lanes,
  output logic                        we3,
  output logic [REG_AW-1:0]           wa3,
  output logic [NUM_LANES*DATA_W-1:0] wd_lanes,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic [1:0]                  alu_ctrl,
  input  logic [DATA_W-1:0]           alu_result,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [2:0] {
    IDLE, READ, EXEC, WRITE, FAULT
  } state_t;

  localparam logic [2:0] MAX_SZ = 3'(NUM_LANES);

  typedef logic [NUM_LANES-1:0][DATA_W-1:0] vec_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [2:0]          size_q;
  logic [REG_AW-1:0]   ra1_q, ra2_q, wa3_q;
  logic [2:0]          lane_q, lane_d;
  vec_t                opa_q, opb_q, res_q;
  vec_t                wd;
  logic                accept;
  logic                capture;
  logic                store;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      size_q  <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa3_q   <= '0;
      lane_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (accept) begin
        op_q   <= req_op;
        size_q <= req_size;
        ra1_q  <= req_ra1;
        ra2_q  <= req_ra2;
        wa3_q  <= req_wa3;
      end
      if (capture) begin
        opa_q <= rs1_lanes;
        opb_q <= rs2_lanes;
      end
      if (store) res_q[lane_q] <= alu_result;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    accept      = 1'b0;
    capture     = 1'b0;
    store       = 1'b0;
    req_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    vector_op   = 1'b0;
    vector_size = '0;
    ra1         = '0;
    ra2         = '0;
    we3         = 1'b0;
    wa3         = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept = 1'b1;
          if (req_size == '0 || req_size > MAX_SZ)
            state_d = FAULT;
          else
            state_d = READ;
        end
      end
      READ: begin
        vector_op   = 1'b1;
        vector_size = size_q;
        ra1         = ra1_q;
        ra2         = ra2_q;
        capture     = 1'b1;
        lane_d      = '0;
        state_d     = abort ? FAULT : EXEC;
      end
      EXEC: begin
        store = 1'b1;
        // Counter stops on the last lane so the ALU operands hold.
        if (abort)
          state_d = FAULT;
        else if (lane_q == size_q - 3'd1)
          state_d = WRITE;
        else
          lane_d = lane_q + 3'd1;
      end
      WRITE: begin
        we3         = 1'b1;
        vector_op   = 1'b1;
        vector_size = size_q;
        wa3         = wa3_q;
        done        = 1'b1;
        state_d     = IDLE;
      end
      FAULT: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes beyond the vector length are written as zero.
  always_comb begin
    wd = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (state_q == WRITE && 3'(i) < size_q)
        wd[i] = res_q[i];
    end
  end

  assign wd_lanes = wd;
  assign alu_a    = opa_q[lane_q];
  assign alu_b    = opb_q[lane_q];
  assign alu_ctrl = op_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Testbench for vector_lane_sequencer: regfile and ALU models around
// the DUT, a timeline-level reference model and directed scenarios.
module tb_vector_lane_sequencer;

  localparam int NL = 5;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int VW = NL * DW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [2:0]    req_size;
  logic [AW-1:0] req_ra1, req_ra2, req_wa3;
  logic          abort;
  logic          vector_op;
  logic [2:0]    vector_size;
  logic [AW-1:0] ra1, ra2, wa3;
  logic [VW-1:0] rs1_lanes, rs2_lanes, wd_lanes;
  logic          we3;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [1:0]    alu_ctrl;
  logic          busy, done, err;

  int checks = 0;
  int failures = 0;
  logic load = 1'b0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  vector_lane_sequencer #(
    .NUM_LANES(NL), .DATA_W(DW), .REG_AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_size(req_size),
    .req_ra1(req_ra1), .req_ra2(req_ra2), .req_wa3(req_wa3),
    .abort(abort),
    .vector_op(vector_op), .vector_size(vector_size),
    .ra1(ra1), .ra2(ra2),
    .rs1_lanes(rs1_lanes), .rs2_lanes(rs2_lanes),
    .we3(we3), .wa3(wa3), .wd_lanes(wd_lanes),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [DW-1:0] alu_f(
    input logic [1:0] op, input logic [DW-1:0] a, b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [VW-1:0] vec_f(
    input logic [1:0] op, input int n,
    input logic [VW-1:0] a, b);
    logic [VW-1:0] r = '0;
    for (int i = 0; i < n; i++)
      r[i*DW +: DW] = alu_f(op, a[i*DW +: DW], b[i*DW +: DW]);
    return r;
  endfunction

  // Shared ALU and physical regfile seen by the DUT.
  assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);

  logic [VW-1:0] rf [16];
  assign rs1_lanes = rf[ra1];
  assign rs2_lanes = rf[ra2];

  localparam logic [VW-1:0] V1 = {5{32'd2}};
  localparam logic [VW-1:0] V2 =
    {32'd7, 32'd6, 32'd5, 32'd4, 32'd3};

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      rf[1] <= V1;
      rf[2] <= V2;
    end else if (we3) begin
      rf[wa3] <= wd_lanes;
    end
  end

  // Reference model: mk counts cycles since a legal accept
  // (1 = read, 2..size+1 = lanes, size+2 = write); mflt marks
  // the single error-completion cycle.
  logic [VW-1:0] mrf [16];
  int            mk;
  bit            mflt;
  logic [1:0]    mop;
  int            msz;
  logic [AW-1:0] mra1, mra2, mwa3;
  logic [VW-1:0] ma, mb, mres;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mk   <= 0;
      mflt <= 1'b0;
      msz  <= 0;
    end else begin
      if (load) begin
        for (int i = 0; i < 16; i++) mrf[i] <= '0;
        mrf[1] <= V1;
        mrf[2] <= V2;
      end
      if (mflt) begin
        mflt <= 1'b0;
      end else if (mk == 0) begin
        if (req_valid) begin
          mop  <= req_op;
          msz  <= int'(req_size);
          mra1 <= req_ra1;
          mra2 <= req_ra2;
          mwa3 <= req_wa3;
          if (req_size >= 1 && int'(req_size) <= NL) begin
            mk   <= 1;
            ma   <= mrf[req_ra1];
            mb   <= mrf[req_ra2];
            mres <= vec_f(req_op, int'(req_size),
                          mrf[req_ra1], mrf[req_ra2]);
          end else begin
            mflt <= 1'b1;
          end
        end
      end else if (abort && mk <= msz + 1) begin
        mk   <= 0;
        mflt <= 1'b1;
      end else if (mk == msz + 2) begin
        mrf[mwa3] <= mres;
        mk <= 0;
      end else begin
        mk <= mk + 1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      bit idle, wr, rd;
      idle = (mk == 0) && !mflt;
      wr   = (mk != 0) && (mk == msz + 2);
      rd   = (mk == 1);
      chk("req_ready", VW'(req_ready), VW'(idle));
      chk("busy", VW'(busy), VW'(!idle));
      chk("done", VW'(done), VW'(mflt || wr));
      chk("err", VW'(err), VW'(mflt));
      chk("we3", VW'(we3), VW'(wr));
      chk("vector_op", VW'(vector_op), VW'(rd || wr));
      chk("vector_size", VW'(vector_size),
          (rd || wr) ? VW'(msz) : '0);
      chk("ra1", VW'(ra1), rd ? VW'(mra1) : '0);
      chk("ra2", VW'(ra2), rd ? VW'(mra2) : '0);
      chk("wa3", VW'(wa3), wr ? VW'(mwa3) : '0);
      chk("wd_lanes", wd_lanes, wr ? mres : '0);
      if (mk >= 2 && mk <= msz + 1) begin
        chk("alu_a", VW'(alu_a), VW'(ma[(mk-2)*DW +: DW]));
        chk("alu_b", VW'(alu_b), VW'(mb[(mk-2)*DW +: DW]));
        chk("alu_ctrl", VW'(alu_ctrl), VW'(mop));
      end
    end
  end

  // Event monitor for latency and pulse-count literals.
  int cyc = 0, acc_cyc = 0, wr_cyc = 0, done_cyc = 0;
  int n_we = 0, n_vop = 0, n_err = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && req_valid && req_ready) acc_cyc <= cyc;
    if (we3) begin
      n_we   <= n_we + 1;
      wr_cyc <= cyc;
    end
    if (vector_op) n_vop <= n_vop + 1;
    if (done) done_cyc <= cyc;
    if (done && err) n_err <= n_err + 1;
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] sz,
                       input logic [AW-1:0] a, b, w);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_size  = sz;
    req_ra1   = a;
    req_ra2   = b;
    req_wa3   = w;
    for (int n = 0; n < 40; n++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", VW'(ok), VW'(1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_timeout", VW'(ok), VW'(1));
  endtask

  int vop0, we0;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_size  = '0;
    req_ra1   = '0;
    req_ra2   = '0;
    req_wa3   = '0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", VW'(req_ready), VW'(1));
    chk("rst_busy", VW'(busy), '0);
    chk("rst_we3", VW'(we3), '0);
    chk("rst_alu_a", VW'(alu_a), '0);
    reset_n = 1'b1;
    load    = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // ADD size 5: v1 + v2 -> v3
    issue(2'd0, 3'd5, 4'd1, 4'd2, 4'd3);
    wait_idle();
    chk("add_latency", VW'(wr_cyc - acc_cyc), VW'(7));
    chk("add_v3", rf[3], {32'd9, 32'd8, 32'd7, 32'd6, 32'd5});
    chk("add_we_count", VW'(n_we), VW'(1));

    // SUB size 3: v2 - v1 -> v5
    issue(2'd1, 3'd3, 4'd2, 4'd1, 4'd5);
    wait_idle();
    chk("sub_latency", VW'(wr_cyc - acc_cyc), VW'(5));
    chk("sub_v5", rf[5], {32'd0, 32'd0, 32'd3, 32'd2, 32'd1});

    // Illegal sizes 0 and 6
    vop0 = n_vop;
    issue(2'd0, 3'd0, 4'd1, 4'd2, 4'd8);
    wait_idle();
    chk("size0_latency", VW'(done_cyc - acc_cyc), VW'(1));
    issue(2'd0, 3'd6, 4'd1, 4'd2, 4'd8);
    wait_idle();
    chk("size6_latency", VW'(done_cyc - acc_cyc), VW'(1));
    chk("illegal_err_count", VW'(n_err), VW'(2));
    chk("illegal_no_we", VW'(n_we), VW'(2));
    chk("illegal_no_vop", VW'(n_vop), VW'(vop0));
    chk("illegal_v8", rf[8], '0);

    // Abort in the second lane cycle
    issue(2'd0, 3'd5, 4'd1, 4'd2, 4'd6);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", VW'(done), VW'(1));
    chk("abort_err", VW'(err), VW'(1));
    @(negedge clk);
    chk("abort_ready", VW'(req_ready), VW'(1));
    chk("abort_no_we", VW'(n_we), VW'(2));
    chk("abort_v6", rf[6], '0);

    // Back-to-back RAW: v1 <= v1+v2, then v4 <= v1+v2
    issue(2'd0, 3'd5, 4'd1, 4'd2, 4'd1);
    issue(2'd0, 3'd5, 4'd1, 4'd2, 4'd4);
    wait_idle();
    chk("b2b_v1", rf[1], {32'd9, 32'd8, 32'd7, 32'd6, 32'd5});
    chk("b2b_v4", rf[4],
        {32'd16, 32'd14, 32'd12, 32'd10, 32'd8});
    chk("b2b_we_count", VW'(n_we), VW'(4));

    // Reset mid-lane-stream, then a normal instruction
    issue(2'd0, 3'd5, 4'd1, 4'd2, 4'd7);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", VW'(busy), '0);
    chk("arst_ready", VW'(req_ready), VW'(1));
    chk("arst_we3", VW'(we3), '0);
    chk("arst_done", VW'(done), '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_no_we", VW'(n_we), VW'(4));
    chk("arst_v7", rf[7], '0);
    we0 = n_we;
    issue(2'd0, 3'd5, 4'd1, 4'd2, 4'd7);
    wait_idle();
    chk("post_rst_v7", rf[7],
        {32'd16, 32'd14, 32'd12, 32'd10, 32'd8});
    chk("post_rst_we", VW'(n_we - we0), VW'(1));

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
Sequences one vector instruction at a time against the vector register file. It reads both source vectors in one cycle and streams the lanes one per cycle through the single shared scalar ALU. It then writes the collected results back in one regfile write cycle. It sits between decode/issue (valid/ready request port) and the vector regfile plus the shared ALU.

Parameters:
NUM_LANES, 5, maximum vector length (lanes per register)
DATA_W, 32, lane width in bits
REG_AW, 4, vector register address width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  instruction request valid
req_ready  out  1  sequencer can accept a request
req_op  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR
req_size  in  3  vector length, legal 1..NUM_LANES
req_ra1  in  REG_AW  source vector A register
req_ra2  in  REG_AW  source vector B register
req_wa3  in  REG_AW  destination vector register
abort  in  1  synchronous cancel of the in-flight instruction
vector_op  out  1  regfile vector enable
vector_size  out  3  regfile lane count
ra1  out  REG_AW  regfile read address A
ra2  out  REG_AW  regfile read address B
rs1_lanes  in  NUM_LANES*DATA_W  regfile A lanes, lane0 in [31:0]
rs2_lanes  in  NUM_LANES*DATA_W  regfile B lanes, lane0 in [31:0]
we3  out  1  regfile write enable
wa3  out  REG_AW  regfile write address
wd_lanes  out  NUM_LANES*DATA_W  write data, lane0 in [31:0]
alu_a  out  DATA_W  shared ALU operand A
alu_b  out  DATA_W  shared ALU operand B
alu_ctrl  out  2  shared ALU op, same encoding as req_op
alu_result  in  DATA_W  shared ALU result, combinational from alu_a/alu_b/alu_ctrl
busy  out  1  instruction in flight
done  out  1  one-cycle completion pulse
err  out  1  qualifies done: illegal size or aborted

Behaviour:
- Reset (async assert, sync release): state IDLE. req_ready=1; busy, done, err, we3 and vector_op=0; all address, size, alu and wd outputs 0; lane counter, operand buffers and result buffers cleared.
- FSM states: IDLE, READ, EXEC, WRITE, FAULT.
- IDLE: req_ready=1. On req_valid&req_ready, latch op, size, ra1, ra2 and wa3.
  - Legal size: go to READ.
  - req_size 0 or >NUM_LANES: go to FAULT.
- READ (1 cycle): vector_op=1, vector_size=latched size, ra1/ra2 driven from the latch. Capture rs1_lanes/rs2_lanes into the operand buffers at the edge. Lane counter=0. Go to EXEC.
- EXEC (size cycles): vector_op=0. Drive alu_a/alu_b from operand buffer[lane] and alu_ctrl=latched op. At each edge store alu_result into result[lane] and increment lane. After lane==size-1 go to WRITE.
- WRITE (1 cycle):
  - we3=1, vector_op=1, vector_size and wa3 from the latch.
  - wd_lanes = result buffers; lanes >= size driven 0.
  - done=1, err=0. Next state IDLE.
- FAULT (1 cycle): done=1, err=1, no regfile access, next state IDLE.
- Latency: request accepted at edge T gives WRITE/done in cycle T+1+size. Throughput is one instruction per size+3 cycles, since IDLE is mandatory between instructions.
- Mandatory IDLE guarantees a back-to-back RAW hazard (wa3 == next ra1/ra2) reads the written data. No bypass is needed.
- req_ready=0 in every state except IDLE. busy=1 in READ, EXEC, WRITE and FAULT.
- abort:
  - Sampled in READ or EXEC: next cycle is FAULT (done=1, err=1), no write.
  - Ignored in IDLE, WRITE and FAULT.
  - abort in the last EXEC cycle still suppresses the write.
- alu_a/alu_b/alu_ctrl hold their last values outside EXEC; they are don't-care for the ALU owner.
- Asserting reset_n low in any state returns to IDLE immediately with we3=0. No partial write is ever issued.

Test Plan:
- Regfile v1 lanes {2,2,2,2,2}, v2 {3,4,5,6,7}. ADD size 5, ra1=1, ra2=2, wa3=3 -> one we3 pulse 7 cycles after accept with wa3=3 and lanes {5,6,7,8,9}; done=1, err=0.
- SUB size 3 v2-v1 -> wd lanes {1,2,3,0,0}, vector_size=3; EXEC lasts exactly 3 cycles; req_ready=0 throughout.
- req_size=0, then req_size=6 -> each gives done=1, err=1 one cycle after accept; we3 and vector_op never asserted.
- abort during the 2nd EXEC cycle of an ADD size 5 -> next cycle done=1, err=1; no we3; req_ready=1 the following cycle.
- Back-to-back: ADD v1+v2 -> v1, then ADD v1+v2 -> v4 held valid -> second accepted in the IDLE after WRITE; v4 = {8,10,12,14,16}.
- reset_n pulsed low mid-EXEC -> outputs return to reset values asynchronously; no we3; a new request after release completes normally.
